// File: rtl/prog_mem_pkg.sv
// Shared definitions for the program-memory arbiter: default widths, FSM and
// owner encodings, and the saturating starvation-counter step.
package prog_mem_pkg;

  localparam int PM_ADDR_W   = 6;
  localparam int PM_DATA_W   = 8;
  localparam int PM_MAX_WAIT = 4;
  localparam int PM_WAIT_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_LDR = 1'b1
  } owner_e;

  // One more lost arbitration, clamped at the configured limit.
  function automatic logic [PM_WAIT_W-1:0] wait_step(input logic [PM_WAIT_W-1:0] cnt,
                                                     input logic [PM_WAIT_W-1:0] limit);
    return (cnt >= limit) ? limit : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/prog_mem_arbiter_if.sv
// Request/response and memory-side signals of the program-memory arbiter.
// master = requesters plus memory array; slave = the arbiter itself.
interface prog_mem_arbiter_if
  import prog_mem_pkg::*;
#(
  parameter int ADDR_W = PM_ADDR_W,
  parameter int DATA_W = PM_DATA_W
);

  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;

  logic              ldr_req;
  logic              ldr_we;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata;
  logic              ldr_ack;
  logic [DATA_W-1:0] ldr_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output cpu_req, cpu_addr, ldr_req, ldr_we, ldr_addr, ldr_wdata, mem_rdata,
    input  cpu_ack, cpu_rdata, ldr_ack, ldr_rdata, mem_addr, mem_we, mem_wdata
  );

  modport slave (
    input  cpu_req, cpu_addr, ldr_req, ldr_we, ldr_addr, ldr_wdata, mem_rdata,
    output cpu_ack, cpu_rdata, ldr_ack, ldr_rdata, mem_addr, mem_we, mem_wdata
  );

endinterface

// File: rtl/prog_mem_arbiter.sv
// CPU-priority arbiter for the single-port program memory, with a starvation
// guard for the loader. Define PROG_MEM_ARB_PERF_EN to add grant counters.
module prog_mem_arbiter
  import prog_mem_pkg::*;
#(
  parameter int ADDR_W   = PM_ADDR_W,
  parameter int DATA_W   = PM_DATA_W,
  parameter int MAX_WAIT = PM_MAX_WAIT
) (
  input  logic                clk,
  input  logic                reset_n,
  prog_mem_arbiter_if.slave   bus
`ifdef PROG_MEM_ARB_PERF_EN
  ,
  output logic [15:0]         cpu_grant_cnt,
  output logic [15:0]         ldr_grant_cnt
`endif
);

  localparam logic [PM_WAIT_W-1:0] WAIT_LIMIT = PM_WAIT_W'(MAX_WAIT);

  state_e                 state,       state_d;
  owner_e                 owner,       owner_d;
  logic                   acc_we,      acc_we_d;
  logic [PM_WAIT_W-1:0]   wait_cnt,    wait_d;
  logic [ADDR_W-1:0]      mem_addr_q,  mem_addr_d;
  logic                   mem_we_q,    mem_we_d;
  logic [DATA_W-1:0]      mem_wdata_q, mem_wdata_d;
  logic                   cpu_ack_q,   cpu_ack_d;
  logic                   ldr_ack_q,   ldr_ack_d;
  logic [DATA_W-1:0]      cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]      ldr_rdata_q, ldr_rdata_d;

  logic ldr_wins;
  logic cpu_wins;

  assign ldr_wins = bus.ldr_req && (!bus.cpu_req || (wait_cnt == WAIT_LIMIT));
  assign cpu_wins = !ldr_wins && bus.cpu_req;

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    state_d     = state;
    owner_d     = owner;
    acc_we_d    = acc_we;
    wait_d      = wait_cnt;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    cpu_ack_d   = 1'b0;
    ldr_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    ldr_rdata_d = ldr_rdata_q;

    case (state)
      ST_IDLE: begin
        if (ldr_wins) begin
          state_d     = ST_ACCESS;
          owner_d     = OWN_LDR;
          acc_we_d    = bus.ldr_we;
          mem_addr_d  = bus.ldr_addr;
          mem_we_d    = bus.ldr_we;
          mem_wdata_d = bus.ldr_wdata;
          wait_d      = '0;
        end else if (cpu_wins) begin
          state_d    = ST_ACCESS;
          owner_d    = OWN_CPU;
          acc_we_d   = 1'b0;
          mem_addr_d = bus.cpu_addr;
          wait_d     = bus.ldr_req ? wait_step(wait_cnt, WAIT_LIMIT) : '0;
        end else begin
          wait_d = '0;
        end
      end

      ST_ACCESS: begin
        // Ack is registered here so it is high for exactly the RESP cycle.
        state_d   = ST_RESP;
        cpu_ack_d = (owner == OWN_CPU);
        ldr_ack_d = (owner == OWN_LDR);
      end

      ST_RESP: begin
        state_d = ST_IDLE;
        if (owner == OWN_CPU) begin
          cpu_rdata_d = bus.mem_rdata;
        end else if (!acc_we) begin
          ldr_rdata_d = bus.mem_rdata;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      owner       <= OWN_CPU;
      acc_we      <= 1'b0;
      wait_cnt    <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      ldr_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
    end else begin
      state       <= state_d;
      owner       <= owner_d;
      acc_we      <= acc_we_d;
      wait_cnt    <= wait_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_ack_q   <= cpu_ack_d;
      ldr_ack_q   <= ldr_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      ldr_rdata_q <= ldr_rdata_d;
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.ldr_ack   = ldr_ack_q;

  // The memory's own output register carries the word during the ack cycle;
  // the local copy takes over from the next cycle and holds until the next ack.
  assign bus.cpu_rdata = cpu_ack_q ? bus.mem_rdata : cpu_rdata_q;
  assign bus.ldr_rdata = (ldr_ack_q && !acc_we) ? bus.mem_rdata : ldr_rdata_q;

`ifdef PROG_MEM_ARB_PERF_EN
  logic [15:0] cpu_grant_cnt_q;
  logic [15:0] ldr_grant_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_grant_cnt_q <= '0;
      ldr_grant_cnt_q <= '0;
    end else begin
      if (cpu_ack_q) cpu_grant_cnt_q <= cpu_grant_cnt_q + 16'd1;
      if (ldr_ack_q) ldr_grant_cnt_q <= ldr_grant_cnt_q + 16'd1;
    end
  end

  assign cpu_grant_cnt = cpu_grant_cnt_q;
  assign ldr_grant_cnt = ldr_grant_cnt_q;
`endif

endmodule

// File: tb/tb_prog_mem_arbiter.sv
// Directed bench for prog_mem_arbiter: behavioural 64x8 synchronous memory,
// per-port scoreboards of expected read data, and arbitration-order checks.
module tb_prog_mem_arbiter;
  import prog_mem_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  logic preload;

  int checks = 0;
  int errors = 0;

  int cpu_acks   = 0;
  int ldr_acks   = 0;
  int we_cycles  = 0;

  logic [7:0] cpu_q[$];
  logic [7:0] ldr_q[$];
  bit         ack_log[$];

  logic [7:0] mem [64];

  prog_mem_arbiter_if #(.ADDR_W(6), .DATA_W(8)) bus ();

`ifdef PROG_MEM_ARB_PERF_EN
  logic [15:0] cpu_grant_cnt;
  logic [15:0] ldr_grant_cnt;
`endif

  prog_mem_arbiter #(.ADDR_W(6), .DATA_W(8), .MAX_WAIT(4)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .bus           (bus)
`ifdef PROG_MEM_ARB_PERF_EN
    ,
    .cpu_grant_cnt (cpu_grant_cnt),
    .ldr_grant_cnt (ldr_grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pre_val(input int a);
    return (a == 4) ? 8'h81 : 8'(a * 3 + 16);
  endfunction

  // Synchronous-read memory, one-cycle latency.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= pre_val(i);
      bus.mem_rdata <= '0;
    end else begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= mem[bus.mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Response monitor: pops the scoreboard on every ack.
  always @(negedge clk) begin
    if (bus.mem_we) we_cycles++;
    if (bus.cpu_ack) begin
      cpu_acks++;
      ack_log.push_back(1'b0);
      if (cpu_q.size() == 0) check("cpu_unexpected_ack", 1, 0);
      else check("cpu_rdata", bus.cpu_rdata, cpu_q.pop_front());
    end
    if (bus.ldr_ack) begin
      ldr_acks++;
      ack_log.push_back(1'b1);
      if (ldr_q.size() == 0) check("ldr_unexpected_ack", 1, 0);
      else check("ldr_rdata", bus.ldr_rdata, ldr_q.pop_front());
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // One access from an idle arbiter; exp_rd is the rdata expected at the ack
  // (for a loader write: the previously held ldr_rdata).
  task automatic access(input bit is_ldr, input bit we, input logic [5:0] a,
                        input logic [7:0] wd, input logic [7:0] exp_rd);
    int n;
    int we0;
    bit seen;
    n    = 0;
    seen = 1'b0;
    we0  = we_cycles;
    if (is_ldr) begin
      bus.ldr_req = 1'b1; bus.ldr_we = we; bus.ldr_addr = a; bus.ldr_wdata = wd;
      ldr_q.push_back(exp_rd);
    end else begin
      bus.cpu_req = 1'b1; bus.cpu_addr = a;
      cpu_q.push_back(exp_rd);
    end
    while (!seen && n < 20) begin
      tick();
      n++;
      seen = is_ldr ? bus.ldr_ack : bus.cpu_ack;
    end
    bus.cpu_req = 1'b0;
    bus.ldr_req = 1'b0;
    if (is_ldr) check("ldr_ack_latency", n, 2);
    else        check("cpu_ack_latency", n, 2);
    check("mem_we_cycles", we_cycles - we0, {31'd0, we});
    tick();
    if (is_ldr) check("ldr_rdata_hold", bus.ldr_rdata, exp_rd);
    else        check("cpu_rdata_hold", bus.cpu_rdata, exp_rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  initial begin
    int n;
    int c0;
    int l0;

    reset_n = 1'b0; preload = 1'b1;
    bus.cpu_req = 1'b0; bus.cpu_addr = '0;
    bus.ldr_req = 1'b0; bus.ldr_we = 1'b0; bus.ldr_addr = '0; bus.ldr_wdata = '0;
    repeat (3) tick();
    preload = 1'b0;

    // Reset values.
    check("rst_state",     dut.state, ST_IDLE);
    check("rst_wait_cnt",  dut.wait_cnt, 0);
    check("rst_cpu_ack",   bus.cpu_ack, 0);
    check("rst_ldr_ack",   bus.ldr_ack, 0);
    check("rst_mem_we",    bus.mem_we, 0);
    check("rst_mem_addr",  bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_cpu_rdata", bus.cpu_rdata, 0);
    check("rst_ldr_rdata", bus.ldr_rdata, 0);

    // Ten idle cycles: nothing happens.
    reset_n = 1'b1;
    repeat (10) tick();
    check("idle_cpu_acks",  cpu_acks, 0);
    check("idle_ldr_acks",  ldr_acks, 0);
    check("idle_we_cycles", we_cycles, 0);
    check("idle_mem_addr",  bus.mem_addr, 0);

    // Basic CPU read, loader write, loader read-back.
    access(1'b0, 1'b0, 6'd4, 8'h00, 8'h81);
    access(1'b1, 1'b1, 6'd2, 8'h46, 8'h00);
    check("mem2_written", mem[2], 8'h46);
    access(1'b1, 1'b0, 6'd2, 8'h00, 8'h46);
    access(1'b0, 1'b0, 6'd9, 8'h00, pre_val(9));

    // Address change after the grant has no effect.
    bus.cpu_req = 1'b1; bus.cpu_addr = 6'd4;
    cpu_q.push_back(8'h81);
    tick();
    bus.cpu_addr = 6'd9;
    tick();
    check("late_addr_ack", bus.cpu_ack, 1);
    bus.cpu_req = 1'b0;
    tick();

    // CPU request raised and dropped while the loader owns the memory.
    c0 = cpu_acks;
    bus.ldr_req = 1'b1; bus.ldr_we = 1'b0; bus.ldr_addr = 6'd9;
    ldr_q.push_back(pre_val(9));
    tick();
    bus.cpu_req = 1'b1; bus.cpu_addr = 6'd4;
    tick();
    check("short_req_ldr_ack", bus.ldr_ack, 1);
    bus.cpu_req = 1'b0; bus.ldr_req = 1'b0;
    repeat (4) tick();
    check("short_req_no_cpu_ack", cpu_acks, c0);

    // Starvation guard: both held -> C C C C L repeating.
    ack_log.delete();
    c0 = cpu_acks + ldr_acks;
    for (int i = 0; i < 8; i++) cpu_q.push_back(8'h81);
    for (int i = 0; i < 2; i++) ldr_q.push_back(8'h46);
    bus.cpu_req = 1'b1; bus.cpu_addr = 6'd4;
    bus.ldr_req = 1'b1; bus.ldr_we = 1'b0; bus.ldr_addr = 6'd2;
    n = 0;
    while ((cpu_acks + ldr_acks - c0) < 10 && n < 60) begin
      tick();
      n++;
    end
    bus.cpu_req = 1'b0; bus.ldr_req = 1'b0;
    check("starve_ack_total", cpu_acks + ldr_acks - c0, 10);
    tick();
    for (int i = 0; i < 10; i++) begin
      if (i < ack_log.size()) check("starve_order", ack_log[i], (i % 5) == 4);
    end
    check("starve_cpu_q_left", cpu_q.size(), 0);
    check("starve_ldr_q_left", ldr_q.size(), 0);
    repeat (2) tick();
    check("wait_cnt_cleared", dut.wait_cnt, 0);

    // Asynchronous reset in the ACCESS cycle of a loader read.
    l0 = ldr_acks;
    bus.ldr_req = 1'b1; bus.ldr_we = 1'b0; bus.ldr_addr = 6'd4;
    tick();
    check("pre_reset_state", dut.state, ST_ACCESS);
    reset_n = 1'b0;
    #1;
    check("mid_rst_state",     dut.state, ST_IDLE);
    check("mid_rst_ldr_ack",   bus.ldr_ack, 0);
    check("mid_rst_mem_addr",  bus.mem_addr, 0);
    check("mid_rst_mem_we",    bus.mem_we, 0);
    check("mid_rst_ldr_rdata", bus.ldr_rdata, 0);
    check("mid_rst_cpu_rdata", bus.cpu_rdata, 0);
    bus.ldr_req = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (4) tick();
    check("mid_rst_no_ack", ldr_acks, l0);
    access(1'b1, 1'b0, 6'd2, 8'h00, 8'h46);

    // 3 CPU + 2 loader accesses since the reset.
    access(1'b0, 1'b0, 6'd4, 8'h00, 8'h81);
    access(1'b0, 1'b0, 6'd9, 8'h00, pre_val(9));
    access(1'b0, 1'b0, 6'd7, 8'h00, pre_val(7));
    access(1'b1, 1'b0, 6'd9, 8'h00, pre_val(9));
`ifdef PROG_MEM_ARB_PERF_EN
    check("cpu_grant_cnt", cpu_grant_cnt, 16'd3);
    check("ldr_grant_cnt", ldr_grant_cnt, 16'd2);
    force dut.cpu_grant_cnt_q = 16'hFFFF;
    tick();
    release dut.cpu_grant_cnt_q;
    access(1'b0, 1'b0, 6'd4, 8'h00, 8'h81);
    check("cpu_grant_cnt_wrap", cpu_grant_cnt, 16'd0);
    check("ldr_grant_cnt_hold", ldr_grant_cnt, 16'd2);
`endif

    check("final_cpu_q_empty", cpu_q.size(), 0);
    check("final_ldr_q_empty", ldr_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_mem_arbiter.md
Name: prog_mem_arbiter

Overview:
- Shares the single-port 64x8 program memory between two requesters:
  - the CPU instruction-fetch port (read-only);
  - a loader/debug port (read/write), used to download and inspect programs while the core runs.
- Fixed priority to the CPU, with a starvation guard so the loader always progresses.
- Sits between the CPU core, the loader, and the memory array (synchronous read, 1-cycle latency).

Parameters:
- ADDR_W, 6: memory address width (64 words).
- DATA_W, 8: memory word width.
- MAX_WAIT, 4: consecutive lost arbitrations after which a pending loader request wins. Range 1..15.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  CPU fetch request; held until cpu_ack.
- cpu_addr  in  ADDR_W  fetch address; stable while cpu_req is high.
- cpu_ack  out  1  one-cycle pulse; cpu_rdata valid in that cycle.
- cpu_rdata  out  DATA_W  fetched word; registered, holds until the next CPU ack.
- ldr_req  in  1  loader request; held until ldr_ack.
- ldr_we  in  1  1 = write, 0 = read; stable with ldr_req.
- ldr_addr  in  ADDR_W  loader address.
- ldr_wdata  in  DATA_W  loader write data.
- ldr_ack  out  1  one-cycle completion pulse.
- ldr_rdata  out  DATA_W  read data, valid with ldr_ack; unchanged by writes.
- mem_addr  out  ADDR_W  registered memory address.
- mem_we  out  1  registered memory write enable.
- mem_wdata  out  DATA_W  registered memory write data.
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_addr is presented.

Behaviour:
- Reset (asynchronous, any state, including mid-access):
  - state=IDLE; all acks 0; mem_we 0; mem_addr 0; mem_wdata 0.
  - cpu_rdata 0; ldr_rdata 0; wait counter 0.
  - Any in-flight access is dropped with no ack. An in-progress write may or may not have landed.
- States: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE: samples requests.
  - Winner selection:
    - loader wins if ldr_req && (!cpu_req || wait_cnt == MAX_WAIT);
    - otherwise the CPU wins if cpu_req;
    - no requests: stay in IDLE.
  - On a win:
    - register owner, mem_addr, and (loader only) mem_we = ldr_we, mem_wdata = ldr_wdata;
    - go to ACCESS.
- ACCESS: memory samples address/write.
  - mem_we is high exactly this one cycle for a loader write.
  - The CPU never asserts mem_we.
  - Next state: RESP.
- RESP:
  - Owner's ack = 1 for exactly one cycle.
  - Owner's rdata <= mem_rdata (reads only).
  - mem_we = 0. Next state: IDLE.
- Latency: request seen in IDLE -> ack 2 cycles later (3-cycle occupancy per access). Back-to-back throughput is 1 access per 3 cycles.
- Starvation counter:
  - Increments (saturating at MAX_WAIT) when an IDLE arbitration has ldr_req and cpu_req both high and the CPU wins.
  - Clears when the loader wins, or when ldr_req is low in IDLE.
- Handshake rules:
  - Requester drops req the cycle after ack. A req still high then is a new request.
  - Req deasserted before a grant is ignored. No ack is issued.
  - Req/addr/data changes after the grant (in ACCESS/RESP) have no effect on the current access.
- Simultaneous cpu_req and ldr_req with wait_cnt < MAX_WAIT: CPU wins.
- Address wrap: none. Addresses are used as-is within ADDR_W.

Optional Feature:
- Macro PROG_MEM_ARB_PERF_EN.
- Defined:
  - adds outputs cpu_grant_cnt and ldr_grant_cnt (16 bits each);
  - each increments on its own ack and wraps at 16'hFFFF -> 0;
  - both reset to 0.
- Undefined: ports and counters are absent. Arbitration behaviour is identical.

Decomposition:
- Shared package prog_mem_pkg:
  - ADDR_W/DATA_W defaults;
  - state encoding constants ST_IDLE=0, ST_ACCESS=1, ST_RESP=2;
  - owner encoding OWN_CPU=0, OWN_LDR=1.
- Sub-module: none. A single module is natural.

Test Plan:
- Reset then idle: no reqs for 10 cycles -> all acks 0, mem_we never 1, outputs 0.
- CPU read: mem[4]=8'h81, cpu_req with cpu_addr=4 -> cpu_ack pulses exactly 2 cycles after the IDLE sample, cpu_rdata=8'h81, mem_we=0 throughout.
- Loader write then read:
  - write addr 2, data 8'h46 -> ldr_ack, with mem_we high exactly one cycle (ACCESS);
  - read addr 2 -> ldr_rdata=8'h46.
- Starvation, MAX_WAIT=4: cpu_req and ldr_req held continuously -> CPU acked 4 times, then loader acked, then the CPU again; the pattern repeats.
- Reset mid-access: assert reset_n=0 during ACCESS of a loader read -> no ldr_ack; state IDLE and outputs 0 immediately (asynchronous); a fresh request after release completes normally.
- PROG_MEM_ARB_PERF_EN: 3 CPU plus 2 loader accesses -> cpu_grant_cnt=3, ldr_grant_cnt=2. Preload 16'hFFFF via forced state -> one more ack wraps the count to 0.
